// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-requester SD block-port arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned RQ_IDX_W = 1;
  typedef logic [RQ_IDX_W-1:0] rq_idx_t;

  localparam rq_idx_t RQ0 = rq_idx_t'(0);
  localparam rq_idx_t RQ1 = rq_idx_t'(1);

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic rq_idx_t rr_pick(input logic req0, input logic req1,
                                      input rq_idx_t last);
    if (req0 && req1) begin
      return (last == RQ1) ? RQ0 : RQ1;
    end else if (req1) begin
      return RQ1;
    end else begin
      return RQ0;
    end
  endfunction

endpackage

// File: rtl/sd_ack_sync.sv
// Two-flop level synchronizer for SPI-domain handshake signals.
module sd_ack_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sd_req_arbiter.sv
// Grants one of two disk controllers the shared SD block port, sequences
// the rd/wr command against the synchronized ack and steers the buffer bus.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic [31:0] rq0_lba,
  input  logic [31:0] rq1_lba,
  input  logic        rq0_rd,
  input  logic        rq1_rd,
  input  logic        rq0_wr,
  input  logic        rq1_wr,
  output logic        rq0_busy,
  output logic        rq1_busy,
  output logic        rq0_done,
  output logic        rq1_done,
  output logic        rq0_err,
  output logic        rq1_err,
  input  logic [7:0]  rq0_buff_din,
  input  logic [7:0]  rq1_buff_din,
  output logic        rq0_buff_wr,
  output logic        rq1_buff_wr,
  output logic [8:0]  buff_addr,
  output logic [7:0]  buff_dout,

  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);

  logic                 ack_s;

  state_e               state_q, state_d;
  rq_idx_t              grant_q, grant_d;
  rq_idx_t              last_q,  last_d;
  logic                 busy_q,  busy_d;
  logic [31:0]          lba_q,   lba_d;
  logic                 rd_q,    rd_d;
  logic                 wr_q,    wr_d;
  logic                 done_q,  done_d;
  logic                 err_q,   err_d;
  logic [TIMEOUT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]           arm_q,   arm_d;

  logic                 req0, req1;
  rq_idx_t              pick;
  logic                 sel_rd;
  op_e                  sel_op;
  logic [TIMEOUT_W-1:0] cnt_inc;

  sd_ack_sync u_ack_sync (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .d_i    (sd_ack),
    .q_o    (ack_s)
  );

  assign req0 = rq0_rd | rq0_wr;
  assign req1 = rq1_rd | rq1_wr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= RQ0;
      last_q  <= RQ1;
      busy_q  <= 1'b0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      arm_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  // The synchronizer resets to 0, so a still-high sd_ack needs two cycles to
  // reach ack_s; arm_q holds off grants until the drain check is meaningful.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    busy_d  = busy_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    arm_d   = {arm_q[0], 1'b1};

    pick    = rr_pick(req0, req1, last_q);
    sel_rd  = (pick == RQ1) ? rq1_rd : rq0_rd;
    sel_op  = sel_rd ? OP_RD : OP_WR;
    cnt_inc = cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (arm_q[1] && !ack_s && (req0 || req1)) begin
          grant_d = pick;
          busy_d  = 1'b1;
          lba_d   = (pick == RQ1) ? rq1_lba : rq0_lba;
          rd_d    = (sel_op == OP_RD);
          wr_d    = (sel_op == OP_WR);
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_inc;
        if (ack_s) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_XFER;
        end else if (&cnt_inc) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_XFER: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign sd_lba   = lba_q;
  assign sd_rd    = rd_q;
  assign sd_wr    = wr_q;

  // grant_q is kept after release so the done/err pulses decode to the owner.
  assign rq0_busy = busy_q & (grant_q == RQ0);
  assign rq1_busy = busy_q & (grant_q == RQ1);
  assign rq0_done = done_q & (grant_q == RQ0);
  assign rq1_done = done_q & (grant_q == RQ1);
  assign rq0_err  = err_q  & (grant_q == RQ0);
  assign rq1_err  = err_q  & (grant_q == RQ1);

  assign rq0_buff_wr = sd_buff_wr & rq0_busy;
  assign rq1_buff_wr = sd_buff_wr & rq1_busy;
  assign buff_addr   = sd_buff_addr;
  assign buff_dout   = sd_buff_dout;

  always_comb begin
    sd_buff_din = '0;
    if (busy_q) begin
      sd_buff_din = (grant_q == RQ1) ? rq1_buff_din : rq0_buff_din;
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed self-checking bench for sd_req_arbiter (TIMEOUT_W=4).
module tb_sd_req_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rq0_lba = '0, rq1_lba = '0;
  logic        rq0_rd = 1'b0, rq1_rd = 1'b0, rq0_wr = 1'b0, rq1_wr = 1'b0;
  logic        rq0_busy, rq1_busy, rq0_done, rq1_done, rq0_err, rq1_err;
  logic [7:0]  rq0_buff_din = '0, rq1_buff_din = '0;
  logic        rq0_buff_wr, rq1_buff_wr;
  logic [8:0]  buff_addr;
  logic [7:0]  buff_dout;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;

  int n_chk  = 0;
  int n_pass = 0;

  sd_req_arbiter #(.TIMEOUT_W(4)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .rq0_lba      (rq0_lba),
    .rq1_lba      (rq1_lba),
    .rq0_rd       (rq0_rd),
    .rq1_rd       (rq1_rd),
    .rq0_wr       (rq0_wr),
    .rq1_wr       (rq1_wr),
    .rq0_busy     (rq0_busy),
    .rq1_busy     (rq1_busy),
    .rq0_done     (rq0_done),
    .rq1_done     (rq1_done),
    .rq0_err      (rq0_err),
    .rq1_err      (rq1_err),
    .rq0_buff_din (rq0_buff_din),
    .rq1_buff_din (rq1_buff_din),
    .rq0_buff_wr  (rq0_buff_wr),
    .rq1_buff_wr  (rq1_buff_wr),
    .buff_addr    (buff_addr),
    .buff_dout    (buff_dout),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    rq0_rd = 1'b0; rq0_wr = 1'b0; rq1_rd = 1'b0; rq1_wr = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
  endtask

  // Cycles from raising sd_ack until sd_rd/sd_wr are seen low (0 = never).
  task automatic ack_rise(output int lat);
    lat = 0;
    sd_ack = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (!sd_rd && !sd_wr) begin
        lat = i;
        break;
      end
    end
  endtask

  // Drops sd_ack, waits for the done pulse and withdraws the served request.
  task automatic ack_fall(input int rq, output int ndone, output int lat);
    ndone = 0;
    lat   = 0;
    sd_ack = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      if (rq0_done || rq1_done) begin
        ndone++;
        lat = i;
        check("busy_at_done", {30'd0, rq1_busy, rq0_busy}, 32'd0);
        check("done_owner", {30'd0, rq1_done, rq0_done}, (rq == 0) ? 32'd1 : 32'd2);
        if (rq == 0) begin rq0_rd = 1'b0; rq0_wr = 1'b0; end
        else         begin rq1_rd = 1'b0; rq1_wr = 1'b0; end
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, nd, c0, c1, bad, k, nerr;

    // Reset state
    #12;
    check("rst_outputs", {26'd0, sd_rd, sd_wr, rq0_busy, rq1_busy, rq0_done | rq1_done,
                          rq0_err | rq1_err}, 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    reset_n = 1'b1;
    cyc(3);

    // Single read on rq0
    rq0_rd = 1'b1; rq0_lba = 32'h0000_1234;
    cyc(1);
    check("t1_busy", {30'd0, rq1_busy, rq0_busy}, 32'd1);
    check("t1_lba", sd_lba, 32'h0000_1234);
    check("t1_rdwr", {30'd0, sd_rd, sd_wr}, 32'd2);
    cyc(2);
    check("t1_rd_held", {31'd0, sd_rd}, 32'd1);
    ack_rise(lat);
    check("t1_ack_to_rd_low", lat, 32'd3);

    c0 = 0; c1 = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk_sys);
      sd_buff_wr = 1'b1;
      sd_buff_addr = i[8:0];
      sd_buff_dout = ~i[7:0];
      #1;
      if (rq0_buff_wr) c0++;
      if (rq1_buff_wr) c1++;
      if (buff_addr !== i[8:0] || buff_dout !== ~i[7:0]) bad++;
      #1;
      sd_buff_wr = 1'b0;
      #1;
      if (rq0_buff_wr || rq1_buff_wr) bad++;
    end
    check("t1_rq0_strobes", c0, 32'd512);
    check("t1_rq1_strobes", c1, 32'd0);
    check("t1_passthrough", bad, 32'd0);
    ack_fall(0, nd, lat);
    check("t1_done_count", nd, 32'd1);
    check("t1_done_lat", lat, 32'd3);
    cyc(1);
    check("t1_done_single", {31'd0, rq0_done}, 32'd0);

    // Tie from reset, write data steering
    do_reset();
    rq0_buff_din = 8'h3C; rq1_buff_din = 8'hA5;
    sd_buff_wr = 1'b1;
    #1;
    check("idle_buff_din", sd_buff_din, 32'h00);
    check("idle_buff_wr", {30'd0, rq1_buff_wr, rq0_buff_wr}, 32'd0);
    sd_buff_wr = 1'b0;
    rq0_wr = 1'b1; rq0_lba = 32'h0000_00A0;
    rq1_rd = 1'b1; rq1_lba = 32'h0000_00B1;
    cyc(1);
    check("t2_first_busy", {30'd0, rq1_busy, rq0_busy}, 32'd1);
    check("t2_first_rdwr", {30'd0, sd_rd, sd_wr}, 32'd1);
    check("t2_first_lba", sd_lba, 32'h0000_00A0);
    check("t2_din_rq0", sd_buff_din, 32'h3C);
    ack_rise(lat);
    check("t2_first_ack_lat", lat, 32'd3);
    ack_fall(0, nd, lat);
    check("t2_first_done", nd, 32'd1);
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (rq1_busy) begin k = i; break; end
    end
    check("t2_second_grant_lat", k, 32'd2);
    check("t2_second_rdwr", {30'd0, sd_rd, sd_wr}, 32'd2);
    check("t2_second_lba", sd_lba, 32'h0000_00B1);
    check("t2_din_rq1", sd_buff_din, 32'hA5);
    sd_buff_wr = 1'b1;
    #1;
    check("t2_buff_wr_steer", {30'd0, rq1_buff_wr, rq0_buff_wr}, 32'd2);
    sd_buff_wr = 1'b0;
    ack_rise(lat);
    ack_fall(1, nd, lat);
    check("t2_second_done", nd, 32'd1);
    rq0_rd = 1'b1; rq1_rd = 1'b1;
    cyc(2);
    check("t2_third_tie", {30'd0, rq1_busy, rq0_busy}, 32'd1);

    // Timeout with a pending rq1
    do_reset();
    rq0_rd = 1'b1; rq0_lba = 32'h0000_0005;
    cyc(1);
    check("t3_grant", {30'd0, rq1_busy, rq0_busy}, 32'd1);
    rq1_rd = 1'b1; rq1_lba = 32'h0000_0077;
    k = 0; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (rq0_done || rq1_done) nd++;
      if (rq0_err) begin
        k = i;
        check("t3_rd_at_err", {30'd0, sd_rd, rq0_busy}, 32'd0);
        rq0_rd = 1'b0;
        break;
      end
    end
    check("t3_err_lat", k, 32'd15);
    check("t3_no_done", nd, 32'd0);
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (rq1_busy) begin k = i; break; end
    end
    check("t3_rq1_grant_lat", k, 32'd1);
    check("t3_rq1_cmd", {sd_lba[29:0], sd_rd, sd_wr}, {30'h77, 2'b10});

    // rd+wr together, then reset mid-transfer with ack held
    do_reset();
    rq0_rd = 1'b1; rq0_wr = 1'b1; rq0_lba = 32'h0000_CAFE;
    cyc(1);
    check("t4_rd_priority", {30'd0, sd_rd, sd_wr}, 32'd2);
    ack_rise(lat);
    cyc(1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_outputs", {28'd0, rq0_busy, sd_rd, rq0_done, rq0_err}, 32'd0);
    check("t4_rst_lba", sd_lba, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (rq0_busy || rq0_done || rq0_err || sd_rd || sd_wr) nerr++;
    end
    check("t4_stale_ack_hold", nerr, 32'd0);
    sd_ack = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (rq0_busy) begin k = i; break; end
    end
    check("t4_grant_after_drain", k, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Two-requester arbiter and sequencer for the SD block-level port of the MiST I/O controller interface (`sd_lba`, `sd_rd`, `sd_wr`, `sd_ack`, `sd_buff_*`). Two core-side disk controllers (e.g. FDD and EDD) share one ARM-serviced SD channel. The block grants one requester at a time and drives the read/write command levels the ARM polls. It tracks the SPI-domain `sd_ack` through a synchronizer and steers the sector-buffer byte stream to the granted requester.

## Interface
Parameters:
- `TIMEOUT_W`, 24: width of the ack-wait timeout counter; timeout fires after 2^TIMEOUT_W−1 cycles in ISSUE.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rq0_lba`, `rq1_lba` in 32: sector address, held stable while the request level is high.
- `rq0_rd`, `rq1_rd`, `rq0_wr`, `rq1_wr` in 1: request levels, held high until `rqN_done` or `rqN_err`.
- `rq0_busy`, `rq1_busy` out 1: high while requester N is granted.
- `rq0_done`, `rq1_done` out 1: one-cycle pulse, transfer complete.
- `rq0_err`, `rq1_err` out 1: one-cycle pulse, timeout abort.
- `rq0_buff_din`, `rq1_buff_din` in 8: write data from the requester sector buffer.
- `rq0_buff_wr`, `rq1_buff_wr` out 1: gated copy of `sd_buff_wr`.
- `buff_addr` out 9, `buff_dout` out 8: broadcast of `sd_buff_addr` and `sd_buff_dout`.
- `sd_lba` out 32, `sd_rd` out 1, `sd_wr` out 1: to the I/O controller.
- `sd_ack` in 1: from the I/O controller, SPI domain (asynchronous).
- `sd_buff_addr` in 9, `sd_buff_dout` in 8, `sd_buff_wr` in 1: from the I/O controller.
- `sd_buff_din` out 8: to the I/O controller.

## Operation
- `ack_s` is `sd_ack` passed through a 2-flop synchronizer; the reset value of both flops is 0.
- States: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - Stays in IDLE while `ack_s`=1, so a stale ack after reset is drained first.
  - Otherwise, if either requester has rd|wr high, grant it and go to ISSUE.
  - If both request, grant the requester that was not granted last (round-robin). `last` resets to 1, so requester 0 wins the first tie.
  - On grant: latch `sd_lba` ← `rqN_lba`. Latch op = rd when `rqN_rd`=1, otherwise wr. If rd and wr are both high, rd takes precedence.
- ISSUE:
  - Drive `sd_rd` or `sd_wr` high per the latched op.
  - On the first cycle `ack_s`=1: drop `sd_rd`/`sd_wr` and go to XFER.
  - When the counter reaches all-ones: drop `sd_rd`/`sd_wr`, pulse `rqN_err`, release the grant and go to IDLE.
- XFER: wait for `ack_s`=0, then go to DONE. There is no timeout in XFER; the ARM owns the transfer length.
- DONE: pulse `rqN_done`, clear the grant, set `last`=N, go to IDLE.
- Steering:
  - `sd_buff_din` = granted `rqN_buff_din` (combinational mux); 0 when nothing is granted.
  - `rqN_buff_wr` = `sd_buff_wr` & grant==N, combinational.
  - `buff_addr` and `buff_dout` are pure pass-through.
- A requester dropping its level mid-grant is ignored; the sequence completes, and `done` still pulses.
- Reset values:
  - All outputs 0: `sd_rd`, `sd_wr`, busy, done, err, and `sd_lba`=0.
  - State IDLE, counter 0.
  - Asynchronous reset mid-transfer aborts with no done/err pulse.

## Timing
- Request high in IDLE at cycle N: `busy` and `sd_lba` are valid at N+1, and `sd_rd`/`sd_wr` are high at N+1. All are registered.
- `sd_ack` rising edge: `ack_s` high 2–3 cycles later; `sd_rd`/`sd_wr` low the cycle after `ack_s` rises.
- `sd_ack` falling edge: `ack_s` low 2–3 cycles later; `done` pulses 1 cycle after that, and `busy` falls in the same cycle as `done`.
- The next grant occurs no earlier than the cycle after DONE.
- The timeout counter clears on ISSUE entry and increments each ISSUE cycle.
- Buffer write strobes have zero-cycle latency through the block.

## Structure
- Package `sd_arb_pkg`:
  - State encoding (IDLE=0, ISSUE=1, XFER=2, DONE=3).
  - Op constants (OP_RD=0, OP_WR=1).
  - Requester index width.
- Sub-module `sd_ack_sync`: 2-flop synchronizer with asynchronous active-low reset, reused for any SPI-domain level.
- Everything else (FSM, round-robin state, counter, muxes) is in `sd_req_arbiter`.

## Test plan
- Single read, rq0_rd=1, lba=0x00001234: `sd_lba`=0x1234 and `sd_rd`=1 at N+1. After `sd_ack` rises, `sd_rd`=0 within 4 cycles. Drive 512 `sd_buff_wr` strobes: 512 `rq0_buff_wr` strobes, 0 on rq1. One `rq0_done` pulse.
- Simultaneous rq0_wr and rq1_rd from reset: rq0 is served first with `sd_wr`=1. rq1 is served next with `sd_rd`=1. A third tie is granted to rq0.
- Write data: granted rq1 with rq1_buff_din=0xA5 → `sd_buff_din`=0xA5; with nothing granted → 0x00.
- Timeout with TIMEOUT_W=4 and no ack: `rq0_err` pulses 15 cycles after ISSUE entry, `sd_rd`=0, no done pulse. A pending rq1 is then granted.
- Both rd and wr high on rq0 → `sd_rd`=1 and `sd_wr`=0.
- Reset asserted in XFER with `sd_ack` still high: outputs go to 0 immediately. After release, no grant is issued until `sd_ack` falls plus 2 cycles.
